// File: rtl/instruction_utilities.sv
// Shared instruction-fetch types: buffered fetch entry and fetch FSM state.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package instruction_utilities;

    // One buffered instruction word together with its PC and status flags
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
        logic        len_bad;
    } fetch_entry_t;

    // RUN issues sequential fetches; HALT stops issuing after an access fault
    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] FETCH_STEP = 32'd4;

    // Redirect targets are forced onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch_entry_t with flush and occupancy; len_bad stored only with NEBULA_FETCH_LEN_CHECK_EN.
// Latency: a write is visible at the head on the cycle after it is written (registered storage).
// Backpressure: rd_rdy pops the head; a write into a full buffer is taken only when the same cycle pops.
module fetch_fifo
    import instruction_utilities::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_vld,
    input  fetch_entry_t             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output fetch_entry_t             rd_dat,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   data_mem_d [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   pc_mem_d   [DEPTH];
    logic          fault_mem_q [DEPTH];
    logic          fault_mem_d [DEPTH];
`ifdef NEBULA_FETCH_LEN_CHECK_EN
    logic          len_bad_mem_q [DEPTH];
    logic          len_bad_mem_d [DEPTH];
`else
    logic          unused_len_bad;
    assign unused_len_bad = wr_dat.len_bad;
`endif
    logic rd_fire;
    logic wr_en;

    assign rd_vld    = (count_q != '0);
    assign rd_fire   = rd_vld && rd_rdy;
    assign wr_en     = wr_vld && ((count_q != FULL_CNT) || rd_fire);
    assign occupancy = count_q;

    // Next pointer, count and storage; flush discards everything including a same-cycle write
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_mem_d  = data_mem_q;
        pc_mem_d    = pc_mem_q;
        fault_mem_d = fault_mem_q;
`ifdef NEBULA_FETCH_LEN_CHECK_EN
        len_bad_mem_d = len_bad_mem_q;
`endif
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                data_mem_d[wr_ptr_q]  = wr_dat.data;
                pc_mem_d[wr_ptr_q]    = wr_dat.pc;
                fault_mem_d[wr_ptr_q] = wr_dat.fault;
`ifdef NEBULA_FETCH_LEN_CHECK_EN
                len_bad_mem_d[wr_ptr_q] = wr_dat.len_bad;
`endif
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW + 1)'(wr_en) - (AW + 1)'(rd_fire);
        end
    end

    // State registers; storage is cleared on reset so the head reads as zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i]  <= '0;
                pc_mem_q[i]    <= '0;
                fault_mem_q[i] <= 1'b0;
`ifdef NEBULA_FETCH_LEN_CHECK_EN
                len_bad_mem_q[i] <= 1'b0;
`endif
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_mem_q  <= data_mem_d;
            pc_mem_q    <= pc_mem_d;
            fault_mem_q <= fault_mem_d;
`ifdef NEBULA_FETCH_LEN_CHECK_EN
            len_bad_mem_q <= len_bad_mem_d;
`endif
        end
    end

    // Head entry presented to the reader
    always_comb begin
        rd_dat.data  = data_mem_q[rd_ptr_q];
        rd_dat.pc    = pc_mem_q[rd_ptr_q];
        rd_dat.fault = fault_mem_q[rd_ptr_q];
`ifdef NEBULA_FETCH_LEN_CHECK_EN
        rd_dat.len_bad = len_bad_mem_q[rd_ptr_q];
`else
        rd_dat.len_bad = 1'b0;
`endif
    end

endmodule

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with credit-limited requests, redirect flush and fault halt (NEBULA_FETCH_LEN_CHECK_EN adds length check).
// Latency: request in cycle N, 1-cycle memory response in N+1, inst_valid in N+2.
// Backpressure: requests stop once buffered + in-flight reaches DEPTH; the decoder stalls via inst_ready.
module fetch_queue
    import instruction_utilities::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    output logic        inst_len_bad
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] occupancy;
    logic          req_fire;
    logic          rsp_accept;
    logic          rsp_drop;
    logic          credit_ok;
    fetch_entry_t  wr_entry;
    fetch_entry_t  rd_entry;

    assign req_fire   = imem_req_valid && imem_req_ready;
    assign rsp_accept = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    assign rsp_drop   = imem_rsp_valid && !redirect_valid && (drop_q != '0);
    // In-flight requests hold a slot so every response always has room to land
    assign credit_ok  = ({1'b0, occupancy} + {1'b0, outstanding_q}) < CREDITS;
    assign imem_req_addr = fetch_pc_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a faulting response halts fetch until the next redirect
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FETCH_RUN;
        end else if (rsp_accept && imem_rsp_err) begin
            state_d = FETCH_HALT;
        end
    end

    // FSM output: request whenever running, credited and not being redirected
    always_comb begin
        imem_req_valid = rst_n && (state_q == FETCH_RUN) && credit_ok && !redirect_valid;
    end

    // PC tracking and credit/drop accounting; the redirect cycle's response is counted then discarded
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = align_word(redirect_pc);
            rsp_pc_d   = align_word(redirect_pc);
            drop_d     = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + FETCH_STEP;
            end
            if (rsp_accept) begin
                rsp_pc_d = rsp_pc_q + FETCH_STEP;
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Build the buffer entry for an accepted response
    always_comb begin
        wr_entry.data  = imem_rsp_data;
        wr_entry.pc    = rsp_pc_q;
        wr_entry.fault = imem_rsp_err;
`ifdef NEBULA_FETCH_LEN_CHECK_EN
        wr_entry.len_bad = (imem_rsp_data[1:0] != 2'b11) || (imem_rsp_data[4:2] == 3'b111);
`else
        wr_entry.len_bad = 1'b0;
`endif
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .wr_vld    (rsp_accept),
        .wr_dat    (wr_entry),
        .rd_vld    (inst_valid),
        .rd_rdy    (inst_ready),
        .rd_dat    (rd_entry),
        .occupancy (occupancy)
    );

    assign inst_data    = rd_entry.data;
    assign inst_pc      = rd_entry.pc;
    assign inst_fault   = rd_entry.fault;
    assign inst_len_bad = rd_entry.len_bad;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a bench-side instruction memory model.
// Memory answers each accepted request one cycle later, in order, when auto_rsp is set.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_len_bad;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .inst_len_bad   (inst_len_bad)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cnum = 0;
    logic        auto_rsp;
    logic        ovr_en;
    logic [31:0] err_addr;
    logic [31:0] ovr_tab [4];
    logic        exp_lb  [4];
    logic [31:0] pend [$];
    logic [31:0] req_addr_q [$];
    int          req_cyc_q [$];
    logic [31:0] pop_pc_q [$];
    logic [31:0] pop_dat_q [$];
    logic        pop_flt_q [$];
    logic        pop_lb_q [$];
    int          pop_cyc_q [$];
    int          rc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Instruction word the memory model returns for an address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en) return ovr_tab[a[3:2]];
        return {a[29:0], 2'b11};
    endfunction

    task automatic clear_logs();
        req_addr_q.delete();
        req_cyc_q.delete();
        pop_pc_q.delete();
        pop_dat_q.delete();
        pop_flt_q.delete();
        pop_lb_q.delete();
        pop_cyc_q.delete();
    endtask

    // One clock cycle: log handshakes, then advance to the next falling edge and drive the memory
    task automatic cyc();
        logic [31:0] a;
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_req_addr);
            req_addr_q.push_back(imem_req_addr);
            req_cyc_q.push_back(cnum);
        end
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            pop_pc_q.push_back(inst_pc);
            pop_dat_q.push_back(inst_data);
            pop_flt_q.push_back(inst_fault);
            pop_lb_q.push_back(inst_len_bad);
            pop_cyc_q.push_back(cnum);
        end
        @(negedge clk);
        cnum++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        if (auto_rsp && pend.size() != 0) begin
            a = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(a);
            imem_rsp_err   = (a == err_addr);
        end
    endtask

    // Reset for two cycles, verify reset outputs, release; cycle 0 is the first cycle out of reset
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        auto_rsp       = 1'b0;
        ovr_en         = 1'b0;
        err_addr       = 32'hFFFF_FFFF;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        pend.delete();
        cyc();
        cyc();
        #1;
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_inst_data", inst_data, 0);
        check_eq("rst_inst_pc", inst_pc, 0);
        check_eq("rst_inst_fault", inst_fault, 0);
        check_eq("rst_inst_len_bad", inst_len_bad, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        cnum = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);

        // Streaming from reset: one request and one instruction per cycle
        do_reset();
        inst_ready = 1'b1;
        auto_rsp   = 1'b1;
        repeat (8) cyc();
        check_eq("stream_nreq", req_addr_q.size(), 8);
        for (int i = 0; i < 5; i++) begin
            check_eq("stream_addr", req_addr_q[i], 32'(i * 4));
            check_eq("stream_req_cyc", req_cyc_q[i], i);
        end
        check_eq("stream_npop", pop_pc_q.size(), 6);
        for (int i = 0; i < 4; i++) begin
            check_eq("stream_pc", pop_pc_q[i], 32'(i * 4));
            check_eq("stream_pop_cyc", pop_cyc_q[i], i + 2);
            check_eq("stream_data", pop_dat_q[i], 32'(i * 16 + 3));
            check_eq("stream_fault", pop_flt_q[i], 0);
        end

        // Credits: decoder stalled, exactly DEPTH requests; one pop frees exactly one more
        do_reset();
        inst_ready = 1'b0;
        auto_rsp   = 1'b1;
        repeat (10) cyc();
        check_eq("credit_nreq", req_addr_q.size(), 4);
        check_eq("credit_last_addr", req_addr_q[3], 32'hC);
        check_eq("credit_inst_valid", inst_valid, 1);
        check_eq("credit_head_pc", inst_pc, 32'h0);
        clear_logs();
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        repeat (6) cyc();
        check_eq("credit_npop", pop_pc_q.size(), 1);
        check_eq("credit_pop_pc", pop_pc_q[0], 32'h0);
        check_eq("credit_nreq2", req_addr_q.size(), 1);
        check_eq("credit_addr2", req_addr_q[0], 32'h10);
        check_eq("credit_head_pc2", inst_pc, 32'h4);
        check_eq("credit_req_off", imem_req_valid, 0);

        // Redirect with two requests in flight: stale responses dropped
        do_reset();
        inst_ready = 1'b1;
        auto_rsp   = 1'b0;
        cyc();
        cyc();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1002;
        cyc();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        auto_rsp       = 1'b1;
        cyc();
        check_eq("redir_nreq", req_addr_q.size(), 3);
        check_eq("redir_addr", req_addr_q[2], 32'h1000);
        check_eq("redir_req_cyc", req_cyc_q[2], 3);
        repeat (8) cyc();
        check_eq("redir_pop_pc0", pop_pc_q[0], 32'h1000);
        check_eq("redir_pop_dat0", pop_dat_q[0], 32'h4003);
        check_eq("redir_pop_cyc0", pop_cyc_q[0], 7);
        check_eq("redir_pop_pc1", pop_pc_q[1], 32'h1004);
        check_eq("redir_pop_dat1", pop_dat_q[1], 32'h4013);

        // Access fault halts fetch; in-flight response still delivered; redirect resumes
        do_reset();
        err_addr   = 32'h8;
        inst_ready = 1'b1;
        auto_rsp   = 1'b1;
        repeat (8) cyc();
        check_eq("fault_nreq", req_addr_q.size(), 4);
        check_eq("fault_npop", pop_pc_q.size(), 4);
        check_eq("fault_pc", pop_pc_q[2], 32'h8);
        check_eq("fault_flag", pop_flt_q[2], 1);
        check_eq("fault_prev_flag", pop_flt_q[1], 0);
        check_eq("fault_next_pc", pop_pc_q[3], 32'hC);
        check_eq("fault_next_flag", pop_flt_q[3], 0);
        check_eq("fault_halted", imem_req_valid, 0);
        clear_logs();
        rc = cnum;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        repeat (4) cyc();
        check_eq("resume_addr", req_addr_q[0], 32'h100);
        check_eq("resume_cyc", req_cyc_q[0], rc + 1);
        check_eq("resume_pop_pc", pop_pc_q[0], 32'h100);
        check_eq("resume_pop_flt", pop_flt_q[0], 0);

        // Redirect colliding with a response and a pop
        do_reset();
        inst_ready = 1'b1;
        auto_rsp   = 1'b1;
        repeat (3) cyc();
        check_eq("coll_pre_valid", inst_valid, 1);
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        check_eq("coll_flushed", inst_valid, 0);
        repeat (6) cyc();
        check_eq("coll_addr", req_addr_q[0], 32'h200);
        check_eq("coll_npop", pop_pc_q.size(), 4);
        check_eq("coll_pop_pc0", pop_pc_q[0], 32'h200);
        check_eq("coll_pop_dat0", pop_dat_q[0], 32'h803);
        check_eq("coll_pop_pc1", pop_pc_q[1], 32'h204);

        // Instruction length check on encodings 0x13, 0x01, 0x1F, 0x03
        do_reset();
        ovr_en     = 1'b1;
        ovr_tab    = '{32'h13, 32'h1, 32'h1F, 32'h3};
`ifdef NEBULA_FETCH_LEN_CHECK_EN
        exp_lb     = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        exp_lb     = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        inst_ready = 1'b1;
        auto_rsp   = 1'b1;
        repeat (7) cyc();
        check_eq("len_npop", pop_pc_q.size(), 5);
        for (int i = 0; i < 4; i++) begin
            check_eq("len_data", pop_dat_q[i], ovr_tab[i]);
            check_eq("len_bad", pop_lb_q[i], exp_lb[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
